conv_norm_engine: RTL and testbench
===================================

// Module: conv_norm_engine
// PURPOSE
//  Parametrised successor to the 3x3 convolution/normalisation accelerator on the memory-mapped accel bus.
//  Convolves an IMG_H x 4 image (8-bit pixels) with a 3x3 mask, one output pixel per cycle.
//  Then computes the mean and variance of the outputs and optionally rewrites them zero-mean clamped.
//  FSM-sequenced with go/done/busy control, a cycle counter and a readable result buffer.
// PARAMETERS
//  IMG_H  4  image rows, legal range 3..16; OUT_N = 2*(IMG_H-2) outputs; RES_W = ceil(OUT_N/4) result words
// PORTS
//  clk           in   1   clock, all state changes on the rising edge
//  rst_n         in   1   asynchronous active-low reset
//  addr          in   32  byte address; word index = addr[7:2]
//  wr_en         in   1   write strobe, sampled at clk
//  accel_select  in   1   block select; a write takes effect only when wr_en & accel_select
//  data_in       in   32  write data
//  data_out      out  32  combinational read data for addr[7:2]
//  ctr           out  16  busy-cycle counter (same value as word 9)
//  busy          out  1   high in any state other than IDLE
//  done          out  1   sticky completion flag
// BEHAVIOUR
//  Map (word index): 8 CTRL rd {done,29'b0,mode,busy}, wr bit0=go bit1=mode | 9 CYCLES {16'b0,ctr}
//   10 MEAN {24'b0,mean} | 11 VAR {16'b0,var} | 12..14 mask rows 0..2 | 16..16+IMG_H-1 image rows
//   32..32+RES_W-1 results | any other index reads 32'h1; writes to read-only/unmapped ignored
//  Pixel c (0..3) of a row word = bits [31-8c -: 8]; mask uses columns 0..2 only (bits 7:0 ignored)
//  Output p = 2r+j, r=0..IMG_H-3, j=0..1: conv = sum_{i,k=0..2} mask[i][k]*img[r+i][j+k]
//   products 16b unsigned, 20b sum, saturated to 8'hFF once at the end of the sum
//  Result word k = {out[4k],out[4k+1],out[4k+2],out[4k+3]}, MSB first; unused slots read 0
//  Reset: all regs 0, state IDLE, busy=0, done=0, ctr=0, mode=0, data_out follows the read mux
//  FSM: IDLE -go-> CONV -> MEAN -> NORM -> VAR -> IDLE
//   IDLE: CTRL write with bit0=1 latches mode, clears done, ctr<=0, p<=0, sum<=0 -> CONV
//   CONV: OUT_N cycles; writes out[p], sum+=out[p], p++; after p=OUT_N-1 -> MEAN
//   MEAN: 1 cycle; mean = (sum + OUT_N/2) / OUT_N (constant divide, round half up); p<=0, sq<=0
//   NORM: OUT_N cycles; d=out[p]-mean (signed 9b); sq += d*d;
//    mode=0: out[p] <= d<0 ? 0 : d; mode=1: out[p] unchanged
//   VAR: 1 cycle; var = (sq + OUT_N/2) / OUT_N, saturated to 16 bits; done<=1 -> IDLE
//  Latency: done and busy=0 visible 2*OUT_N+2 cycles after the go-write edge; ctr increments
//   every busy cycle, so ctr = 2*OUT_N+2 at completion, then holds until the next go
//  While busy: CTRL, mask, image and result writes are ignored (go included); reads stay live, so
//   results read mid-run show partial data
//  go in IDLE with done=1: restarts normally, done cleared the cycle busy rises
//  Mode/mask/image writes in IDLE take effect the next cycle; result words are read-only
//  Async reset mid-run: immediate return to IDLE, all registers and results cleared
//  ctr saturates at 16'hFFFF (unreachable for legal IMG_H)
// TESTING
//  Mask rows all 0x01010100, image rows all 0x01010101, go mode=0 -> out=9 each, mean=9, var=0,
//   word 32=0x00000000, done after 10 cycles (IMG_H=4), ctr=10
//  Mask row1=0x00010000, rows 0..2 = 0; image 0x01020304,0x05060708,0x090A0B0C,0x0D0E0F10:
//   mode=1 -> word 32=0x06070A0B, mean=9, var=5; mode=0 -> word 32=0x00000102
//  All mask and image bytes 0xFF -> each conv saturates to 0xFF, mean=255, var=0, mode=1 word 32=0xFFFFFFFF
//  Second go plus an image write issued 3 cycles after go -> both ignored, results/ctr as single run
//  Assert rst_n=0 during NORM -> busy=0, done=0, ctr=0, words 10/11/32 read 0 immediately
//  IMG_H=8: OUT_N=12, three result words 32..34 filled, word 35 reads 32'h1, done after 26 cycles

Source files
------------

// File: rtl/conv_norm_engine.sv
// 3x3 convolution over an IMG_H x 4 image of 8-bit pixels, then mean/variance of the outputs
// with optional zero-mean clamping; go/done/busy control and readback over a word-mapped bus.

module conv_norm_dot3 (
  input  logic [2:0][7:0] a_i,
  input  logic [2:0][7:0] b_i,
  output logic [17:0]     dot_o
);
  always_comb begin
    dot_o = '0;
    for (int k = 0; k < 3; k++) dot_o = dot_o + 18'(16'(a_i[k]) * 16'(b_i[k]));
  end
endmodule

module conv_norm_engine #(
  parameter int IMG_H = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic        accel_select,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [15:0] ctr,
  output logic        busy,
  output logic        done
);
  localparam int OUT_N = 2 * (IMG_H - 2);
  localparam int RES_W = (OUT_N + 3) / 4;
  localparam int PW    = $clog2(OUT_N);
  localparam int RW    = $clog2(IMG_H);
  localparam int OW    = $clog2(4 * RES_W);

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_MEAN, S_NORM, S_VAR} state_t;

  state_t        state_q;
  logic [PW-1:0] p_q;
  logic          mode_q, done_q;
  logic [15:0]   ctr_q, var_q;
  logic [7:0]    mean_q;
  logic [19:0]   sum_q;
  logic [31:0]   sq_q;
  logic [23:0]   mask_q [3];
  logic [31:0]   img_q  [IMG_H];
  // padded to whole result words so unused slots read back as 0
  logic [7:0]    out_q  [4*RES_W];

  logic [5:0] widx;
  logic       wr, unused_addr;
  assign widx        = addr[7:2];
  assign wr          = wr_en & accel_select;
  assign unused_addr = ^{addr[31:8], addr[1:0]};

  logic in_mask, in_img;
  assign in_mask = (widx >= 6'd12) && (widx <= 6'd14);
  assign in_img  = (widx >= 6'd16) && (32'(widx) < 32'(16 + IMG_H));

  // Window for output p: rows r..r+2, pre-shifted left by one pixel when j=1
  logic [2:0][31:0]     rows;
  logic [2:0][2:0][7:0] win, msk;
  logic [2:0][17:0]     dot;
  logic [19:0]          conv_sum;
  logic [7:0]           conv_px;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rows[i] = img_q[RW'(p_q >> 1) + RW'(i)] << (p_q[0] ? 8 : 0);
      for (int k = 0; k < 3; k++) begin
        win[i][k] = rows[i][31-8*k -: 8];
        msk[i][k] = mask_q[2'(i)][23-8*k -: 8];
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_row
    conv_norm_dot3 u_dot (.a_i(win[g]), .b_i(msk[g]), .dot_o(dot[g]));
  end

  assign conv_sum = 20'(dot[0]) + 20'(dot[1]) + 20'(dot[2]);
  assign conv_px  = (|conv_sum[19:8]) ? 8'hFF : conv_sum[7:0];

  logic signed [8:0]  d;
  logic signed [17:0] dw;
  logic [17:0]        dsq;
  logic [31:0]        var_full;
  assign d        = $signed({1'b0, out_q[OW'(p_q)]}) - $signed({1'b0, mean_q});
  assign dw       = d;
  assign dsq      = $unsigned(dw * dw);
  assign var_full = (sq_q + 32'(OUT_N / 2)) / 32'(OUT_N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      ctr_q   <= '0;
      mean_q  <= '0;
      var_q   <= '0;
      sum_q   <= '0;
      sq_q    <= '0;
      for (int i = 0; i < 3; i++)       mask_q[2'(i)] <= '0;
      for (int i = 0; i < IMG_H; i++)   img_q[RW'(i)] <= '0;
      for (int i = 0; i < 4*RES_W; i++) out_q[OW'(i)] <= '0;
    end else begin
      if (state_q != S_IDLE && ctr_q != 16'hFFFF) ctr_q <= ctr_q + 16'd1;
      unique case (state_q)
        S_IDLE: if (wr) begin
          if (widx == 6'd8) begin
            mode_q <= data_in[1];
            if (data_in[0]) begin
              done_q  <= 1'b0;
              ctr_q   <= '0;
              p_q     <= '0;
              sum_q   <= '0;
              state_q <= S_CONV;
            end
          end else if (in_mask) begin
            mask_q[2'(widx - 6'd12)] <= data_in[31:8];
          end else if (in_img) begin
            img_q[RW'(widx - 6'd16)] <= data_in;
          end
        end
        S_CONV: begin
          out_q[OW'(p_q)] <= conv_px;
          sum_q           <= sum_q + 20'(conv_px);
          if (p_q == PW'(OUT_N - 1)) begin
            p_q     <= '0;
            state_q <= S_MEAN;
          end else begin
            p_q <= p_q + PW'(1);
          end
        end
        S_MEAN: begin
          mean_q  <= 8'((sum_q + 20'(OUT_N / 2)) / 20'(OUT_N));
          p_q     <= '0;
          sq_q    <= '0;
          state_q <= S_NORM;
        end
        S_NORM: begin
          sq_q <= sq_q + 32'(dsq);
          if (!mode_q) out_q[OW'(p_q)] <= d[8] ? 8'h00 : d[7:0];
          if (p_q == PW'(OUT_N - 1)) begin
            p_q     <= '0;
            state_q <= S_VAR;
          end else begin
            p_q <= p_q + PW'(1);
          end
        end
        S_VAR: begin
          var_q   <= (|var_full[31:16]) ? 16'hFFFF : var_full[15:0];
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign ctr  = ctr_q;

  always_comb begin
    data_out = 32'h1;
    if (widx == 6'd8)       data_out = {done_q, 29'b0, mode_q, busy};
    else if (widx == 6'd9)  data_out = {16'b0, ctr_q};
    else if (widx == 6'd10) data_out = {24'b0, mean_q};
    else if (widx == 6'd11) data_out = {16'b0, var_q};
    else if (in_mask)       data_out = {mask_q[2'(widx - 6'd12)], 8'h00};
    else if (in_img)        data_out = img_q[RW'(widx - 6'd16)];
    else begin
      for (int k = 0; k < RES_W; k++)
        if (widx == 6'(32 + k))
          data_out = {out_q[OW'(4*k)], out_q[OW'(4*k+1)], out_q[OW'(4*k+2)], out_q[OW'(4*k+3)]};
    end
  end
endmodule

// File: tb/tb_conv_norm_engine.sv
// Bench for conv_norm_engine: IMG_H=4 and IMG_H=8 instances on a shared bus, directed and
// random runs checked against an arithmetic reference model.

module tb_conv_norm_engine;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, data_in, dout4, dout8;
  logic        wr_en, sel4, sel8;
  logic [15:0] ctr4, ctr8;
  logic        busy4, busy8, done4, done8;
  int          n_tests = 0, n_fail = 0;

  int m [3][3];
  int im[16][4];
  int eo[32];
  int emean, evar;

  always #5 clk = ~clk;

  conv_norm_engine #(.IMG_H(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .accel_select(sel4),
    .data_in(data_in), .data_out(dout4), .ctr(ctr4), .busy(busy4), .done(done4));

  conv_norm_engine #(.IMG_H(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .accel_select(sel8),
    .data_in(data_in), .data_out(dout8), .ctr(ctr8), .busy(busy8), .done(done8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic get_busy(input int h);
    return (h == 8) ? busy8 : busy4;
  endfunction
  function automatic logic get_done(input int h);
    return (h == 8) ? done8 : done4;
  endfunction
  function automatic logic [15:0] get_ctr(input int h);
    return (h == 8) ? ctr8 : ctr4;
  endfunction

  task automatic wr(input int h, input int idx, input logic [31:0] d);
    @(negedge clk);
    addr = 32'(idx) << 2; data_in = d; wr_en = 1'b1;
    sel4 = (h == 4); sel8 = (h == 8);
    @(negedge clk);
    wr_en = 1'b0; sel4 = 1'b0; sel8 = 1'b0;
  endtask

  task automatic rd(input int h, input int idx, output logic [31:0] v);
    addr = 32'(idx) << 2;
    #1;
    v = (h == 8) ? dout8 : dout4;
  endtask

  // Reference: straight from the arithmetic definition of the outputs
  task automatic model(input int h, input bit mode);
    int n, s, sq, acc, dd;
    n = 2 * (h - 2); s = 0; sq = 0;
    for (int p = 0; p < 32; p++) eo[p] = 0;
    for (int p = 0; p < n; p++) begin
      acc = 0;
      for (int i = 0; i < 3; i++)
        for (int k = 0; k < 3; k++) acc += m[i][k] * im[p/2 + i][p%2 + k];
      eo[p] = (acc > 255) ? 255 : acc;
      s += eo[p];
    end
    emean = (s + n/2) / n;
    for (int p = 0; p < n; p++) begin
      dd = eo[p] - emean;
      sq += dd * dd;
      if (!mode) eo[p] = (dd < 0) ? 0 : dd;
    end
    evar = (sq + n/2) / n;
    if (evar > 65535) evar = 65535;
  endtask

  task automatic load(input int h);
    logic [31:0] v, w;
    for (int i = 0; i < 3; i++) begin
      w = {8'(m[i][0]), 8'(m[i][1]), 8'(m[i][2]), 8'($urandom)};
      wr(h, 12 + i, w);
      rd(h, 12 + i, v);
      chk($sformatf("h%0d.mask%0d", h, i), v, {w[31:8], 8'h00});
    end
    for (int r = 0; r < h; r++) begin
      w = {8'(im[r][0]), 8'(im[r][1]), 8'(im[r][2]), 8'(im[r][3])};
      wr(h, 16 + r, w);
      rd(h, 16 + r, v);
      chk($sformatf("h%0d.img%0d", h, r), v, w);
    end
  endtask

  task automatic wait_done(input int h, inout int k);
    while (!get_done(h) && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_results(input int h, input bit mode, input string tag);
    int n, rw;
    logic [31:0] v, e;
    n = 2 * (h - 2); rw = (n + 3) / 4;
    chk({tag, ".busy_end"}, 32'(get_busy(h)), 32'd0);
    chk({tag, ".ctr"}, 32'(get_ctr(h)), 32'(2*n + 2));
    rd(h, 9, v);  chk({tag, ".w9"}, v, 32'(2*n + 2));
    rd(h, 8, v);  chk({tag, ".ctrl"}, v, {1'b1, 29'b0, mode, 1'b0});
    rd(h, 10, v); chk({tag, ".mean"}, v, 32'(emean));
    rd(h, 11, v); chk({tag, ".var"}, v, 32'(evar));
    for (int k = 0; k < rw; k++) begin
      e = {8'(eo[4*k]), 8'(eo[4*k+1]), 8'(eo[4*k+2]), 8'(eo[4*k+3])};
      rd(h, 32 + k, v);
      chk($sformatf("%s.res%0d", tag, k), v, e);
    end
    rd(h, 32 + rw, v); chk({tag, ".unmapped"}, v, 32'h1);
  endtask

  task automatic run(input int h, input bit mode, input string tag);
    int k;
    model(h, mode);
    wr(h, 8, {30'b0, mode, 1'b1});
    chk({tag, ".busy_go"}, 32'(get_busy(h)), 32'd1);
    chk({tag, ".done_go"}, 32'(get_done(h)), 32'd0);
    k = 0;
    wait_done(h, k);
    chk({tag, ".latency"}, 32'(k), 32'(4*(h-2) + 2));
    check_results(h, mode, tag);
  endtask

  task automatic rand_pat(input int h);
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) m[i][k] = $urandom_range(0, 7);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < 4; c++) im[r][c] = $urandom_range(0, 255);
  endtask

  task automatic fill(input int mv, input int iv);
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) m[i][k] = mv;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 4; c++) im[r][c] = iv;
  endtask

  initial begin
    logic [31:0] v;
    int k;
    addr = '0; data_in = '0; wr_en = 1'b0; sel4 = 1'b0; sel8 = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst.busy", 32'(busy4), 32'd0);
    chk("rst.done", 32'(done4), 32'd0);
    chk("rst.ctr",  32'(ctr4),  32'd0);
    rd(4, 8, v);  chk("rst.ctrl", v, 32'd0);
    rd(4, 10, v); chk("rst.mean", v, 32'd0);
    rd(4, 32, v); chk("rst.res0", v, 32'd0);
    rd(4, 15, v); chk("rst.hole15", v, 32'h1);
    rd(4, 33, v); chk("rst.res_past", v, 32'h1);
    rst_n = 1'b1;

    // all-ones mask columns and image
    fill(1, 1);
    load(4);
    run(4, 1'b0, "ones");
    rd(4, 10, v); chk("ones.mean9", v, 32'd9);
    rd(4, 32, v); chk("ones.res_zero", v, 32'h0);

    // mode write without go: done stays sticky
    wr(4, 8, 32'h2);
    rd(4, 8, v); chk("modewr.ctrl", v, 32'h8000_0002);

    // centre-tap mask picks out img[r+1][j+1]
    fill(0, 0);
    m[1][1] = 1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) im[r][c] = 4*r + c + 1;
    load(4);
    run(4, 1'b1, "tap.m1");
    rd(4, 32, v); chk("tap.m1.word", v, 32'h0607_0A0B);
    rd(4, 10, v); chk("tap.m1.mean", v, 32'd9);
    rd(4, 11, v); chk("tap.m1.var",  v, 32'd5);
    run(4, 1'b0, "tap.m0");
    rd(4, 32, v); chk("tap.m0.word", v, 32'h0000_0102);

    // saturation
    fill(255, 255);
    load(4);
    run(4, 1'b1, "sat");
    rd(4, 32, v); chk("sat.word", v, 32'hFFFF_FFFF);
    rd(4, 10, v); chk("sat.mean", v, 32'd255);

    for (int t = 0; t < 4; t++) begin
      rand_pat(4);
      load(4);
      run(4, 1'($urandom), $sformatf("rnd4.%0d", t));
    end

    for (int t = 0; t < 2; t++) begin
      rand_pat(8);
      load(8);
      run(8, 1'($urandom), $sformatf("rnd8.%0d", t));
    end

    // writes while busy are dropped
    fill(0, 0);
    m[1][1] = 1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) im[r][c] = 4*r + c + 1;
    load(4);
    model(4, 1'b1);
    wr(4, 8, 32'h3);
    @(negedge clk);
    wr(4, 16, 32'hDEAD_BEEF);
    wr(4, 8, 32'h1);
    k = 5;
    wait_done(4, k);
    chk("busywr.latency", 32'(k), 32'd10);
    check_results(4, 1'b1, "busywr");
    rd(4, 16, v); chk("busywr.img0", v, 32'h0102_0304);

    // async reset in NORM
    fill(1, 1);
    load(4);
    wr(4, 8, 32'h1);
    repeat (6) @(negedge clk);
    chk("midrst.busy_pre", 32'(busy4), 32'd1);
    rd(4, 10, v); chk("midrst.mean_pre", v, 32'd9);
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", 32'(busy4), 32'd0);
    chk("midrst.done", 32'(done4), 32'd0);
    chk("midrst.ctr",  32'(ctr4),  32'd0);
    rd(4, 10, v); chk("midrst.mean", v, 32'd0);
    rd(4, 11, v); chk("midrst.var",  v, 32'd0);
    rd(4, 32, v); chk("midrst.res0", v, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
